// File: rtl/icache_refill_pkg.sv
// Shared constants for the instruction-cache refill path: AXI widths,
// line geometry and AXI response encodings.
package icache_refill_pkg;

    localparam int AXI_ADDR_WIDTH    = 32;
    localparam int ICACHE_LINE_SIZE  = 32;
    localparam int ICACHE_LINE_WORDS = ICACHE_LINE_SIZE / 4;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/icache_refill_if.sv
// AXI read-channel bundle (AR + R only) between the refill master and the
// instruction-memory slave.
interface axi_read_if
    import icache_refill_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_WIDTH
);

    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arlen, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/icache_refill.sv
// Instruction-cache line refill: one INCR burst per miss, beats assembled
// into a full line and handed back to the icache in a single-cycle pulse.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a miss; line buffer/counter/error cleared on accept
// AR      | address phase, arvalid held with stable araddr/arlen
// R       | data phase, rready high, beats written into the line buffer
// RESP    | resp_valid pulse with line and error flag; back to IDLE
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int ADDR_W     = AXI_ADDR_WIDTH,
    parameter int LINE_BYTES = ICACHE_LINE_SIZE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    resp_valid,
    output logic [LINE_BYTES*8-1:0] resp_data,
    output logic                    resp_err,
    axi_read_if.master              axi_if
);

    localparam int BEATS = LINE_BYTES / 4;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);
    localparam logic [7:0]        ARLEN     = 8'(BEATS - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                  state_q;
    logic [ADDR_W-1:0]       araddr_q;
    logic [7:0]              arlen_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic                    resp_valid_q;
    logic                    err_q;
    logic [CNT_W-1:0]        beat_q;
    logic [LINE_BYTES*8-1:0] line_q;

    logic beat_fire;
    logic beat_term;
    logic beat_err;

    // Per-beat termination and error classification for the data phase.
    always_comb begin
        beat_fire = axi_if.rvalid && rready_q;
        beat_term = (beat_q == LAST_BEAT) || axi_if.rlast;
        beat_err  = (axi_if.rresp != AXI_RESP_OKAY)
                 || (axi_if.rlast && (beat_q != LAST_BEAT))
                 || (!axi_if.rlast && (beat_q == LAST_BEAT));
    end

    // Refill sequencer; all bus and response outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            beat_q       <= '0;
            line_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        araddr_q  <= req_addr & ~LINE_MASK;
                        arlen_q   <= ARLEN;
                        arvalid_q <= 1'b1;
                        line_q    <= '0;
                        beat_q    <= '0;
                        err_q     <= 1'b0;
                        state_q   <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (axi_if.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    if (beat_fire) begin
                        for (int i = 0; i < BEATS; i++) begin
                            if (beat_q == CNT_W'(i)) begin
                                line_q[i*32 +: 32] <= axi_if.rdata;
                            end
                        end
                        beat_q <= beat_q + 1'b1;
                        err_q  <= err_q | beat_err;
                        // rready drops with the final beat so a missing
                        // rlast cannot pull in beats past the line.
                        if (beat_term) begin
                            rready_q     <= 1'b0;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_data      = line_q;
    assign resp_err       = err_q;
    assign axi_if.araddr  = araddr_q;
    assign axi_if.arlen   = arlen_q;
    assign axi_if.arvalid = arvalid_q;
    assign axi_if.rready  = rready_q;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: the bench plays the AXI slave cycle by
// cycle and checks bus signals, response timing and the assembled line.
module tb_icache_refill;
    import icache_refill_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         resp_valid;
    logic [255:0] resp_data;
    logic         resp_err;

    int n_tests;
    int n_fail;

    axi_read_if axi ();

    icache_refill dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .axi_if     (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One complete refill. pre=1 means the request was already accepted by
    // the previous call and the DUT is in its first AR cycle.
    task automatic fill(input string name, input logic [31:0] addr, input bit pre,
                        input int ar_wait, input bit bubble, input int err_beat,
                        input int last_beat, input bit mode_a, input bit exp_err,
                        input bit chain, input logic [31:0] next_addr);
        logic [31:0] exp_addr;
        logic [31:0] wd;
        int b;
        exp_addr = addr & ~32'h1F;
        if (!pre) begin
            req_valid = 1'b1;
            req_addr  = addr;
            chk({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
            tick();
            req_valid = 1'b0;
        end
        for (int w = 0; w < ar_wait; w++) begin
            chk({name, "_arvalid_wait"}, {31'd0, axi.arvalid}, 32'd1);
            chk({name, "_araddr_wait"}, axi.araddr, exp_addr);
            chk({name, "_arlen_wait"}, {24'd0, axi.arlen}, 32'd7);
            chk({name, "_rready_early"}, {31'd0, axi.rready}, 32'd0);
            tick();
        end
        chk({name, "_arvalid"}, {31'd0, axi.arvalid}, 32'd1);
        chk({name, "_araddr"}, axi.araddr, exp_addr);
        chk({name, "_arlen"}, {24'd0, axi.arlen}, 32'd7);
        chk({name, "_req_ready_busy"}, {31'd0, req_ready}, 32'd0);
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        chk({name, "_arvalid_drop"}, {31'd0, axi.arvalid}, 32'd0);
        b = 0;
        while (b <= last_beat) begin
            if (bubble && b[0] && axi.rvalid) begin
                axi.rvalid = 1'b0;
                chk({name, "_rready_bubble"}, {31'd0, axi.rready}, 32'd1);
                tick();
                continue;
            end
            chk({name, "_rready"}, {31'd0, axi.rready}, 32'd1);
            chk({name, "_resp_early"}, {31'd0, resp_valid}, 32'd0);
            axi.rvalid = 1'b1;
            axi.rdata  = mode_a ? (32'hA0 + b) : ((b + 1) * 32'h1111_1111);
            axi.rresp  = (b == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            axi.rlast  = (b == last_beat);
            tick();
            b++;
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        axi.rresp  = AXI_RESP_OKAY;
        axi.rdata  = 32'h0;
        if (chain) begin
            req_valid = 1'b1;
            req_addr  = next_addr;
        end
        chk({name, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({name, "_resp_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        chk({name, "_rready_off"}, {31'd0, axi.rready}, 32'd0);
        chk({name, "_req_ready_resp"}, {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (i > last_beat) wd = 32'h0;
            else if (mode_a) wd = 32'hA0 + i;
            else wd = (i + 1) * 32'h1111_1111;
            chk($sformatf("%s_word%0d", name, i), resp_data[i*32 +: 32], wd);
        end
        tick();
        chk({name, "_resp_pulse"}, {31'd0, resp_valid}, 32'd0);
        chk({name, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
        chk({name, "_idle_arvalid"}, {31'd0, axi.arvalid}, 32'd0);
        if (chain) begin
            tick();
            req_valid = 1'b0;
            chk({name, "_chain_accept"}, {31'd0, axi.arvalid}, 32'd1);
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_addr    = 32'h0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'h0;
        axi.rresp   = AXI_RESP_OKAY;
        axi.rlast   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_arvalid", {31'd0, axi.arvalid}, 32'd0);
        chk("rst_araddr", axi.araddr, 32'h0);
        chk("rst_arlen", {24'd0, axi.arlen}, 32'd0);
        chk("rst_rready", {31'd0, axi.rready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_data_lo", resp_data[31:0], 32'h0);
        chk("rst_resp_data_hi", resp_data[255:224], 32'h0);

        // 1: zero-wait slave, resp at cycle 10
        fill("t1", 32'h0000_0104, 1'b0, 0, 1'b0, -1, 7, 1'b0, 1'b0, 1'b0, 32'h0);
        // 2: arready held off for 5 cycles
        fill("t2", 32'h0000_0104, 1'b0, 5, 1'b0, -1, 7, 1'b0, 1'b0, 1'b0, 32'h0);
        // 3: bubbles, second request raised during RESP
        fill("t3", 32'h0000_0104, 1'b0, 0, 1'b1, -1, 7, 1'b0, 1'b0, 1'b1, 32'h2000_003C);
        // 4: SLVERR on beat 3 (request accepted at the end of t3)
        fill("t4", 32'h2000_003C, 1'b1, 0, 1'b0, 3, 7, 1'b0, 1'b1, 1'b0, 32'h0);
        // 5: early rlast on beat 4
        fill("t5", 32'h0000_0104, 1'b0, 0, 1'b0, -1, 4, 1'b1, 1'b1, 1'b0, 32'h0);

        // 6: reset after three beats
        req_valid = 1'b1;
        req_addr  = 32'h0000_0104;
        tick();
        req_valid   = 1'b0;
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            axi.rvalid = 1'b1;
            axi.rdata  = 32'hDEAD_0000 + b;
            axi.rlast  = 1'b0;
            tick();
        end
        axi.rvalid = 1'b0;
        chk("t6_busy_rready", {31'd0, axi.rready}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_rst_rready", {31'd0, axi.rready}, 32'd0);
        chk("t6_rst_arvalid", {31'd0, axi.arvalid}, 32'd0);
        chk("t6_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("t6_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("t6_rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("t6_rst_data", resp_data[31:0], 32'h0);
        fill("t6", 32'h0000_0200, 1'b0, 0, 1'b0, -1, 7, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
